// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction fetch stage. Owns the PC, issues one-outstanding
//             req/gnt/rvalid fetches to instruction ROM and presents a
//             registered instruction to decode, with stall, redirect and a
//             one-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_gnt_i,
   input  logic        rom_rvalid_i,
   input  logic [31:0] rom_rdata_i,
   output logic [31:0] ins_o,
   output logic [31:0] ins_addr_o,
   output logic        ins_valid_o
);

   // IDLE: nothing outstanding, WAIT: one outstanding to keep,
   // KILL: one outstanding whose data must be dropped after a redirect.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      KILL = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pend_addr;
   logic        skid_valid;
   logic [31:0] skid_data;
   logic [31:0] skid_addr;

   logic        issue;
   logic        accepted;

   // Request only when a slot is (or becomes) free and the response could
   // land somewhere: a stalled valid output with a response arriving sends
   // that response to the skid, so a new request then could overflow it.
   always_comb begin
      rom_req_o = !rst && !jump_flag_i && !skid_valid
                  && ((state == IDLE) || rom_rvalid_i)
                  && !(hold_i && ins_valid_o && rom_rvalid_i && (state == WAIT));
      rom_addr_o = pc;
      issue      = rom_req_o && rom_gnt_i;
      accepted   = (state == WAIT) && rom_rvalid_i;
   end

   // Next-state logic for the outstanding-request tracker.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (issue)
               state_next = WAIT;
         end
         WAIT: begin
            if (rom_rvalid_i)
               state_next = issue ? WAIT : IDLE;
            else if (jump_flag_i)
               state_next = KILL;
         end
         KILL: begin
            if (rom_rvalid_i)
               state_next = issue ? WAIT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus PC and pending-address tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         pend_addr <= RESET_PC;
      end else begin
         state <= state_next;
         if (jump_flag_i)
            pc <= jump_addr_i & ~32'd3;
         else if (issue)
            pc <= pc + 32'd4;
         if (issue)
            pend_addr <= pc;
      end
   end

   // Output register and skid buffer, flush first, then stall, then drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins_o       <= NOP_INST;
         ins_addr_o  <= RESET_PC;
         ins_valid_o <= 1'b0;
         skid_valid  <= 1'b0;
         skid_data   <= NOP_INST;
         skid_addr   <= RESET_PC;
      end else if (jump_flag_i) begin
         ins_o       <= NOP_INST;
         ins_valid_o <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (hold_i) begin
         if (accepted) begin
            skid_valid <= 1'b1;
            skid_data  <= rom_rdata_i;
            skid_addr  <= pend_addr;
         end
      end else if (skid_valid) begin
         ins_o       <= skid_data;
         ins_addr_o  <= skid_addr;
         ins_valid_o <= 1'b1;
         skid_valid  <= 1'b0;
      end else if (accepted) begin
         ins_o       <= rom_rdata_i;
         ins_addr_o  <= pend_addr;
         ins_valid_o <= 1'b1;
      end else begin
         ins_o       <= NOP_INST;
         ins_valid_o <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Directed self-checking bench for if_fetch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] XKEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        hold;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic        rom_gnt;
   logic        rom_rvalid;
   logic [31:0] rom_rdata;
   logic [31:0] ins;
   logic [31:0] ins_addr;
   logic        ins_valid;

   // second instance for the wrap-around reset PC
   logic        rom_req2;
   logic [31:0] rom_addr2;
   logic        rom_rvalid2 = 1'b0;
   logic [31:0] rom_rdata2  = 32'h0;
   logic [31:0] ins2;
   logic [31:0] ins_addr2;
   logic        ins_valid2;

   // ROM response source: automatic responder or hand-driven values
   logic        rom_auto;
   logic        auto_rv = 1'b0;
   logic [31:0] auto_rd = 32'h0;
   logic        man_rv;
   logic [31:0] man_rd;

   int n_checks = 0;
   int n_pass   = 0;

   assign rom_rvalid = rom_auto ? auto_rv : man_rv;
   assign rom_rdata  = rom_auto ? auto_rd : man_rd;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
      .hold_i(hold), .rom_req_o(rom_req), .rom_addr_o(rom_addr),
      .rom_gnt_i(rom_gnt), .rom_rvalid_i(rom_rvalid), .rom_rdata_i(rom_rdata),
      .ins_o(ins), .ins_addr_o(ins_addr), .ins_valid_o(ins_valid)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) dut2 (
      .clk(clk), .rst(rst), .jump_flag_i(1'b0), .jump_addr_i(32'h0),
      .hold_i(1'b0), .rom_req_o(rom_req2), .rom_addr_o(rom_addr2),
      .rom_gnt_i(1'b1), .rom_rvalid_i(rom_rvalid2), .rom_rdata_i(rom_rdata2),
      .ins_o(ins2), .ins_addr_o(ins_addr2), .ins_valid_o(ins_valid2)
   );

   // Zero-wait ROM: respond one cycle after each issue with addr^XKEY.
   initial begin
      logic        iss;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         iss = rom_req && rom_gnt;
         a   = rom_addr;
         @(posedge clk);
         #2;
         auto_rv = iss;
         auto_rd = a ^ XKEY;
      end
   end

   // Same zero-wait ROM for the second instance.
   initial begin
      logic        iss;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         iss = rom_req2;
         a   = rom_addr2;
         @(posedge clk);
         #2;
         rom_rvalid2 = iss;
         rom_rdata2  = a ^ XKEY;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Advance until a valid instruction appears; it must be the expected one.
   task automatic wait_valid(input string tag, input logic [31:0] exp_addr, input int bound);
      bit found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         next_cycle();
         sample();
         if (ins_valid) begin
            found = 1'b1;
            check({tag, "_addr"}, ins_addr, exp_addr);
            check({tag, "_data"}, ins, exp_addr ^ XKEY);
         end
      end
      if (!found)
         check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; jump_flag = 1'b0; jump_addr = 32'h0; hold = 1'b0;
      rom_gnt = 1'b1; rom_auto = 1'b1; man_rv = 1'b0; man_rd = 32'h0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      sample();
      check("rst_valid", {31'd0, ins_valid}, 32'd0);
      check("rst_ins",   ins, NOP);
      check("rst_iaddr", ins_addr, 32'h0);
      check("rst_req",   {31'd0, rom_req}, 32'd0);
      check("rst2_iaddr", ins_addr2, 32'hFFFF_FFF8);
      check("rst2_valid", {31'd0, ins_valid2}, 32'd0);
      check("rst2_ins",   ins2, NOP);

      // ---------------- streaming fetch + wrap ----------------
      next_cycle(); rst = 1'b0;                        // c0
      sample();
      check("c0_req",  {31'd0, rom_req}, 32'd1);
      check("c0_addr", rom_addr, 32'h0);
      check("c0_valid", {31'd0, ins_valid}, 32'd0);
      check("wrap0", rom_addr2, 32'hFFFF_FFF8);
      next_cycle();                                    // c1
      sample();
      check("c1_addr", rom_addr, 32'h4);
      check("wrap1", rom_addr2, 32'hFFFF_FFFC);
      next_cycle();                                    // c2
      sample();
      check("c2_addr", rom_addr, 32'h8);
      check("c2_valid", {31'd0, ins_valid}, 32'd1);
      check("c2_iaddr", ins_addr, 32'h0);
      check("c2_ins", ins, 32'hA5A5_0000);
      check("wrap2", rom_addr2, 32'h0000_0000);
      next_cycle();                                    // c3
      sample();
      check("c3_iaddr", ins_addr, 32'h4);
      check("c3_ins", ins, 32'hA5A5_0004);

      // ---------------- hold with skid ----------------
      for (int i = 0; i < 3; i++) begin                // c4..c6
         next_cycle(); hold = 1'b1;
         sample();
         check("hold_iaddr", ins_addr, 32'h8);
         check("hold_ins", ins, 32'hA5A5_0008);
         check("hold_valid", {31'd0, ins_valid}, 32'd1);
         check("hold_req", {31'd0, rom_req}, 32'd0);
      end
      next_cycle(); hold = 1'b0;                       // c7
      sample();
      check("rel_req", {31'd0, rom_req}, 32'd0);
      next_cycle();                                    // c8
      sample();
      check("skid_iaddr", ins_addr, 32'hC);
      check("skid_ins", ins, 32'hA5A5_000C);
      check("skid_valid", {31'd0, ins_valid}, 32'd1);
      check("post_skid_addr", rom_addr, 32'h10);
      next_cycle();                                    // c9
      next_cycle();                                    // c10: 0x14 response arriving
      jump_flag = 1'b1; jump_addr = 32'h0000_0103;
      sample();
      check("after_skid_iaddr", ins_addr, 32'h10);
      check("after_skid_ins", ins, 32'hA5A5_0010);
      check("jmp_req", {31'd0, rom_req}, 32'd0);

      // ---------------- redirect ----------------
      next_cycle(); jump_flag = 1'b0;                  // c11
      sample();
      check("jmp_valid", {31'd0, ins_valid}, 32'd0);
      check("jmp_ins", ins, NOP);
      check("jmp_req2", {31'd0, rom_req}, 32'd1);
      check("jmp_addr", rom_addr, 32'h100);
      wait_valid("jmp_first", 32'h100, 6);

      // ---------------- grant stall ----------------
      next_cycle(); jump_flag = 1'b1; jump_addr = 32'h0000_0020;
      sample();
      for (int i = 0; i < 4; i++) begin
         next_cycle(); jump_flag = 1'b0; rom_gnt = 1'b0;
         sample();
         check("gnt0_req", {31'd0, rom_req}, 32'd1);
         check("gnt0_addr", rom_addr, 32'h20);
         check("gnt0_valid", {31'd0, ins_valid}, 32'd0);
      end
      next_cycle(); rom_gnt = 1'b1;
      sample();
      check("gnt1_addr", rom_addr, 32'h20);
      wait_valid("gnt_first", 32'h20, 6);
      wait_valid("gnt_second", 32'h24, 3);

      // ---------------- redirect with response still outstanding ----------
      next_cycle(); rom_auto = 1'b0; man_rv = 1'b0; rst = 1'b1;
      sample();
      check("rst_mid_valid", {31'd0, ins_valid}, 32'd0);
      check("rst_mid_iaddr", ins_addr, 32'h0);
      next_cycle(); rst = 1'b0;                        // m0 issue 0x0
      sample();
      check("m0_addr", rom_addr, 32'h0);
      next_cycle(); jump_flag = 1'b1; jump_addr = 32'h40;   // m1 WAIT, no rvalid
      sample();
      check("m1_req", {31'd0, rom_req}, 32'd0);
      next_cycle(); jump_flag = 1'b0;                  // m2 KILL
      sample();
      check("kill_req", {31'd0, rom_req}, 32'd0);
      next_cycle(); man_rv = 1'b1; man_rd = 32'hBAD0_BAD0;  // m3 stale data
      sample();
      check("kill_reissue_req", {31'd0, rom_req}, 32'd1);
      check("kill_reissue_addr", rom_addr, 32'h40);
      next_cycle(); man_rd = 32'h40 ^ XKEY;            // m4
      sample();
      check("kill_dropped", {31'd0, ins_valid}, 32'd0);
      next_cycle(); man_rd = 32'h44 ^ XKEY;            // m5
      sample();
      check("kill_next_iaddr", ins_addr, 32'h40);
      check("kill_next_ins", ins, 32'h40 ^ XKEY);
      next_cycle(); man_rv = 1'b0;                     // m6 WAIT on 0x48
      sample();
      check("m6_iaddr", ins_addr, 32'h44);

      // ---------------- reset mid-fetch, stale response ----------------
      next_cycle(); rst = 1'b1;                        // m7
      sample();
      check("rstw_valid", {31'd0, ins_valid}, 32'd0);
      check("rstw_ins", ins, NOP);
      check("rstw_iaddr", ins_addr, 32'h0);
      check("rstw_req", {31'd0, rom_req}, 32'd0);
      next_cycle(); rst = 1'b0; man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;  // m8
      sample();
      check("rstw_first_req", {31'd0, rom_req}, 32'd1);
      check("rstw_first_addr", rom_addr, 32'h0);
      next_cycle(); man_rv = 1'b0;                     // m9
      sample();
      check("stale_valid", {31'd0, ins_valid}, 32'd0);
      check("stale_ins", ins, NOP);
      next_cycle(); man_rv = 1'b1; man_rd = 32'h0 ^ XKEY;   // m10
      sample();
      check("m10_valid", {31'd0, ins_valid}, 32'd0);
      next_cycle(); man_rv = 1'b0;                     // m11
      sample();
      check("rstw_out_iaddr", ins_addr, 32'h0);
      check("rstw_out_ins", ins, XKEY);
      check("rstw_out_valid", {31'd0, ins_valid}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard bound on simulation time.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
